// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART receiver and the CPU register block.
// Status flags come from an occupancy count; the head byte reads 8'h00 when empty.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_data_ready,
    input  logic [7:0]            rx_data,
    input  logic                  pop,
    input  logic                  clr_ovf,
    output logic [7:0]            dout,
    output logic                  rx_ready,
    output logic                  rx_half,
    output logic                  rx_full,
    output logic                  rx_overflow,
    output logic [DEPTH_LOG2:0]   rx_count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic [CW-1:0]         count;
    logic                  ovf;
    logic                  is_empty;
    logic                  is_full;
    logic                  do_push;
    logic                  do_pop;
    logic                  drop;

    // A pop on a full FIFO frees the slot the concurrent push needs.
    always_comb begin
        is_empty = (count == '0);
        is_full  = (count == CW'(DEPTH));
        do_pop   = pop && !is_empty;
        do_push  = rx_data_ready && (!is_full || do_pop);
        drop     = rx_data_ready && is_full && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + DEPTH_LOG2'(1);
            if (do_pop)  rp <= rp + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wp] <= rx_data;
    end

    // Sticky drop flag; a new drop outranks a concurrent clear.
    always_ff @(posedge clk) begin
        if (rst)          ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end

    always_comb begin
        dout        = is_empty ? 8'h00 : mem[rp];
        rx_ready    = !is_empty;
        rx_half     = (count >= CW'(DEPTH / 2));
        rx_full     = is_full;
        rx_overflow = ovf;
        rx_count    = count;
    end

endmodule
